// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_if
// Purpose  : Groups the request/status signals of reset_sequencer.
//            The "slave" modport is the sequencer's view; the "master"
//            modport is the view of the logic that issues requests and
//            reads status back.
// Signals  : rst_req   - request level, synchronous to the sequencer clock
//            rst_out   - registered active-high reset to downstream logic
//            busy      - sequence in progress (ASSERT or HOLDOFF)
//            done      - one-cycle pulse at the end of a sequence
//            rst_count - saturating count of accepted triggers
// Revision : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   rst_req;
  logic                   rst_out;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] rst_count;

  modport slave (
    input  rst_req,
    output rst_out,
    output busy,
    output done,
    output rst_count
  );

  modport master (
    output rst_req,
    input  rst_out,
    input  busy,
    input  done,
    input  rst_count
  );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Turns a synchronized reset request level into a fixed-length
//            reset pulse followed by a release hold-off, with busy/done
//            status and a saturating count of accepted requests. A power-on
//            sequence runs out of the block's own reset.
// Ports    : clk           - clock, rising edge
//            rst           - asynchronous active-high reset
//            bus (slave)   - rst_req in; rst_out, busy, done, rst_count out
// Params   : ASSERT_CYCLES  - periods rst_out is high per sequence (>= 1)
//            HOLDOFF_CYCLES - periods from rst_out release to done (0 skips)
//            COUNT_WIDTH    - width of rst_count
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int ASSERT_CYCLES  = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int COUNT_WIDTH    = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  reset_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (ASSERT_CYCLES > HOLDOFF_CYCLES) ? ASSERT_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(ASSERT_CYCLES - 1);
  // Guarded so a zero hold-off does not produce a negative load value; the
  // load is never used in that configuration.
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD =
    CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_q;
  logic                   rst_out_q, rst_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   trig;

  // Registered state. Reset places the machine directly in ASSERT with a
  // full count so the power-on sequence is identical to a triggered one.
  // req_q resets high so a request level already present at reset release
  // is not mistaken for a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ASSERT;
      cnt_q     <= ASSERT_LOAD;
      req_q     <= 1'b1;
      rst_out_q <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= bus.rst_req;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  // Next-state, shared down-counter and status decode. A trigger always
  // wins over counter expiry, so a request landing on the last cycle of a
  // phase restarts the assert phase instead of finishing the sequence.
  always_comb begin
    trig    = bus.rst_req & ~req_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_ASSERT;
          cnt_d   = ASSERT_LOAD;
        end
      end

      S_ASSERT: begin
        if (trig) begin
          cnt_d = ASSERT_LOAD;
        end else if (cnt_q == '0) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HOLDOFF;
            cnt_d   = HOLDOFF_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HOLDOFF: begin
        if (trig) begin
          state_d = S_ASSERT;
          cnt_d   = ASSERT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of the next-state decode, so they
    // change on the same edge that samples the trigger.
    rst_out_d = (state_d == S_ASSERT);
    busy_d    = (state_d != S_IDLE);

    count_d = count_q;
    if (trig && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rst_count = count_q;

endmodule
`default_nettype wire
